// File: rtl/dcache_port_scheduler.sv
// Purpose: arbitrates the single-ported D-cache data array among refill, load and store-drain requesters, with drain anti-starvation and a fence flush sequence.
// Latency: zero; grants and arr_* are combinational from state and valids, and the array samples at the next rising edge.
// Backpressure: a ready rises only with its own valid; a requester that is not granted sees ready=0 and holds its request.
module dcache_port_scheduler #(
  parameter int LINE_WORDS = 4,
  parameter int MAX_STALL  = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        load_req_valid,
  input  logic [31:0] load_req_addr,
  output logic        load_req_ready,
  input  logic        sb_drain_valid,
  input  logic [31:0] sb_drain_addr,
  input  logic [31:0] sb_drain_data,
  output logic        sb_drain_ready,
  input  logic        refill_valid,
  input  logic [31:0] refill_addr,
  input  logic [31:0] refill_data,
  output logic        refill_ready,
  input  logic        fence_req,
  output logic        fence_done,
  output logic        arr_en,
  output logic        arr_we,
  output logic [31:0] arr_addr,
  output logic [31:0] arr_wdata,
  output logic [1:0]  grant_src
);

  localparam int BW  = $clog2(LINE_WORDS);
  localparam int OFF = BW + 2;
  localparam int SW  = $clog2(MAX_STALL + 1);

  localparam logic [1:0] G_NONE   = 2'd0;
  localparam logic [1:0] G_LOAD   = 2'd1;
  localparam logic [1:0] G_DRAIN  = 2'd2;
  localparam logic [1:0] G_REFILL = 2'd3;

  typedef enum logic [1:0] {S_IDLE, S_REFILL, S_FENCE} state_t;

  state_t         state_q, state_d;
  logic [BW-1:0]  beat_q, beat_d;
  logic [SW-1:0]  stall_q, stall_d;
  // Only the line-aligned upper bits of the refill base are kept.
  logic [31:OFF]  base_q, base_d;
  logic [1:0]     src;

  // Address bits below word (or line, for refill) granularity never matter.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{load_req_addr[1:0], sb_drain_addr[1:0], refill_addr[OFF-1:0]};

  // State register: FSM state, refill beat counter, drain stall counter, refill base.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      beat_q  <= '0;
      stall_q <= '0;
      base_q  <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      stall_q <= stall_d;
      base_q  <= base_d;
    end
  end

  // Next-state logic and grant selection; everything is forced quiet while in reset.
  always_comb begin
    state_d        = state_q;
    beat_d         = beat_q;
    stall_d        = stall_q;
    base_d         = base_q;
    src            = G_NONE;
    fence_done     = 1'b0;
    load_req_ready = 1'b0;
    sb_drain_ready = 1'b0;
    refill_ready   = 1'b0;
    arr_en         = 1'b0;
    arr_we         = 1'b0;
    arr_addr       = '0;
    arr_wdata      = '0;

    if (reset) begin
      case (state_q)
        S_IDLE: begin
          if (refill_valid) begin
            src     = G_REFILL;
            base_d  = refill_addr[31:OFF];
            beat_d  = BW'(1);
            state_d = S_REFILL;
          end else if (sb_drain_valid && stall_q == SW'(MAX_STALL)) begin
            src = G_DRAIN;
          end else if (load_req_valid) begin
            src = G_LOAD;
          end else if (sb_drain_valid) begin
            src = G_DRAIN;
          end else if (fence_req) begin
            state_d = S_FENCE;
          end
          // Count only cycles where a waiting drain was passed over.
          if (!sb_drain_valid || src == G_DRAIN) begin
            stall_d = '0;
          end else if (stall_q != SW'(MAX_STALL)) begin
            stall_d = stall_q + SW'(1);
          end
        end
        S_REFILL: begin
          if (refill_valid) begin
            src    = G_REFILL;
            beat_d = beat_q + BW'(1);
            if (beat_q == BW'(LINE_WORDS - 1)) begin
              state_d = S_IDLE;
            end
          end
        end
        S_FENCE: begin
          if (sb_drain_valid) begin
            src = G_DRAIN;
          end else begin
            fence_done = 1'b1;
            state_d    = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase

      case (src)
        G_LOAD: begin
          load_req_ready = 1'b1;
          arr_en         = 1'b1;
          arr_addr       = {load_req_addr[31:2], 2'b00};
        end
        G_DRAIN: begin
          sb_drain_ready = 1'b1;
          arr_en         = 1'b1;
          arr_we         = 1'b1;
          arr_addr       = {sb_drain_addr[31:2], 2'b00};
          arr_wdata      = sb_drain_data;
        end
        G_REFILL: begin
          refill_ready = 1'b1;
          arr_en       = 1'b1;
          arr_we       = 1'b1;
          arr_wdata    = refill_data;
          // Beat 0 comes straight from the input; later beats from the captured base.
          if (state_q == S_IDLE) begin
            arr_addr = {refill_addr[31:OFF], {OFF{1'b0}}};
          end else begin
            arr_addr = {base_q, beat_q, 2'b00};
          end
        end
        default: ;
      endcase
    end
  end

  assign grant_src = src;

endmodule

// File: tb/tb_dcache_port_scheduler.sv
// Bench for dcache_port_scheduler: directed scenarios with literal expectations,
// plus a cycle-by-cycle reference model compared at every falling edge.
module tb_dcache_port_scheduler;

  localparam int LW = 4;
  localparam int MS = 8;

  logic        clock;
  logic        reset;
  logic        load_req_valid;
  logic [31:0] load_req_addr;
  logic        load_req_ready;
  logic        sb_drain_valid;
  logic [31:0] sb_drain_addr;
  logic [31:0] sb_drain_data;
  logic        sb_drain_ready;
  logic        refill_valid;
  logic [31:0] refill_addr;
  logic [31:0] refill_data;
  logic        refill_ready;
  logic        fence_req;
  logic        fence_done;
  logic        arr_en;
  logic        arr_we;
  logic [31:0] arr_addr;
  logic [31:0] arr_wdata;
  logic [1:0]  grant_src;

  int n_checks = 0;
  int n_fail   = 0;

  dcache_port_scheduler #(.LINE_WORDS(LW), .MAX_STALL(MS)) dut (
    .clock(clock), .reset(reset),
    .load_req_valid(load_req_valid), .load_req_addr(load_req_addr), .load_req_ready(load_req_ready),
    .sb_drain_valid(sb_drain_valid), .sb_drain_addr(sb_drain_addr), .sb_drain_data(sb_drain_data),
    .sb_drain_ready(sb_drain_ready),
    .refill_valid(refill_valid), .refill_addr(refill_addr), .refill_data(refill_data),
    .refill_ready(refill_ready),
    .fence_req(fence_req), .fence_done(fence_done),
    .arr_en(arr_en), .arr_we(arr_we), .arr_addr(arr_addr), .arr_wdata(arr_wdata),
    .grant_src(grant_src)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ---------------- reference model ----------------
  // mode: 0 idle, 1 streaming a refill line, 2 flushing for a fence
  int          m_mode  = 0;
  int          m_beat  = 0;
  int          m_stall = 0;
  logic [31:0] m_base  = 32'h0;
  int          who;
  logic        e_done;
  logic [31:0] e_addr, e_wdata;
  logic [71:0] exp_v, act_v;

  always @(negedge clock) begin
    who    = 0;
    e_done = 1'b0;
    e_addr = 32'h0;
    e_wdata = 32'h0;
    if (!reset) begin
      exp_v   = '0;
      m_mode  = 0;
      m_beat  = 0;
      m_stall = 0;
      m_base  = 32'h0;
    end else begin
      if (m_mode == 0) begin
        if (refill_valid)                       who = 3;
        else if (sb_drain_valid && m_stall >= MS) who = 2;
        else if (load_req_valid)                who = 1;
        else if (sb_drain_valid)                who = 2;
      end else if (m_mode == 1) begin
        if (refill_valid) who = 3;
      end else begin
        if (sb_drain_valid) who = 2;
        else e_done = 1'b1;
      end
      if (who == 1) e_addr = load_req_addr & ~32'd3;
      if (who == 2) begin
        e_addr  = sb_drain_addr & ~32'd3;
        e_wdata = sb_drain_data;
      end
      if (who == 3) begin
        e_wdata = refill_data;
        if (m_mode == 0) e_addr = refill_addr & ~(32'(LW * 4) - 32'd1);
        else             e_addr = m_base + 32'(m_beat * 4);
      end
      exp_v = {who == 1, who == 2, who == 3, e_done, who != 0, who >= 2,
               e_addr, e_wdata, 2'(who)};
      // advance the model by one clock
      if (m_mode == 0) begin
        if (!sb_drain_valid || who == 2) m_stall = 0;
        else if (m_stall < MS)           m_stall = m_stall + 1;
        if (who == 3) begin
          m_base = e_addr;
          m_beat = 1;
          m_mode = 1;
        end else if (who == 0 && fence_req) begin
          m_mode = 2;
        end
      end else if (m_mode == 1) begin
        if (who == 3) begin
          m_beat = (m_beat + 1) % LW;
          if (m_beat == 0) m_mode = 0;
        end
      end else if (e_done) begin
        m_mode = 0;
      end
    end
    act_v = {load_req_ready, sb_drain_ready, refill_ready, fence_done, arr_en, arr_we,
             arr_addr, arr_wdata, grant_src};
    n_checks++;
    if (act_v !== exp_v) begin
      n_fail++;
      $display("FAIL model_cycle t=%0t actual=%h required=%h", $time, act_v, exp_v);
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s t=%0t actual=%h required=%h", name, $time, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    reset          = 1'b0;
    load_req_valid = 1'b1;
    load_req_addr  = 32'h0000_0100;
    sb_drain_valid = 1'b1;
    sb_drain_addr  = 32'h0000_0207;
    sb_drain_data  = 32'hDEAD_BEEF;
    refill_valid   = 1'b1;
    refill_addr    = 32'h1000_0014;
    refill_data    = 32'h0000_00A0;
    fence_req      = 1'b1;

    // Reset with every request high: everything quiet.
    #2;
    chk("rst_grant", 32'(grant_src), 32'd0);
    chk("rst_readies", 32'({load_req_ready, sb_drain_ready, refill_ready, fence_done}), 32'd0);
    chk("rst_arr", 32'({arr_en, arr_we}) | arr_addr | arr_wdata, 32'd0);
    tick(); tick();
    settle();
    chk("rst_grant_held", 32'(grant_src), 32'd0);

    // Refill burst with one gap, loads stalled throughout.
    tick();
    reset = 1'b1; sb_drain_valid = 1'b0; fence_req = 1'b0;
    settle();
    chk("rel_grant_refill", 32'(grant_src), 32'd3);
    chk("refill_b0_addr", arr_addr, 32'h1000_0010);
    chk("refill_b0_wdata", arr_wdata, 32'h0000_00A0);
    chk("refill_b0_load_rdy", 32'(load_req_ready), 32'd0);
    tick(); refill_data = 32'hA1; settle();
    chk("refill_b1_addr", arr_addr, 32'h1000_0014);
    tick(); refill_valid = 1'b0; settle();
    chk("refill_gap_grant", 32'(grant_src), 32'd0);
    chk("refill_gap_load_rdy", 32'(load_req_ready), 32'd0);
    tick(); refill_valid = 1'b1; refill_data = 32'hA2; settle();
    chk("refill_b2_addr", arr_addr, 32'h1000_0018);
    tick(); refill_data = 32'hA3; settle();
    chk("refill_b3_addr", arr_addr, 32'h1000_001C);
    chk("refill_b3_we", 32'(arr_we), 32'd1);
    tick(); refill_valid = 1'b0; settle();
    chk("post_refill_load", 32'(grant_src), 32'd1);
    chk("load_addr", arr_addr, 32'h0000_0100);
    chk("load_wdata", arr_wdata, 32'd0);

    // Loads outrank drain until the drain has waited MAX_STALL cycles.
    for (int i = 0; i < 11; i++) begin
      tick(); sb_drain_valid = 1'b1; settle();
      chk($sformatf("stall_grant_%0d", i), 32'(grant_src), (i == MS) ? 32'd2 : 32'd1);
      if (i == MS) begin
        chk("stall_drain_rdy", 32'(sb_drain_ready), 32'd1);
        chk("stall_drain_addr", arr_addr, 32'h0000_0204);
        chk("stall_drain_wdata", arr_wdata, 32'hDEAD_BEEF);
      end
    end

    // Fence: enter from a quiet IDLE, then flush three entries while a load waits.
    tick(); load_req_valid = 1'b0; sb_drain_valid = 1'b0; fence_req = 1'b1; settle();
    chk("fence_enter_grant", 32'(grant_src), 32'd0);
    for (int k = 0; k < 3; k++) begin
      tick(); load_req_valid = 1'b1; sb_drain_valid = 1'b1; sb_drain_data = 32'h100 + 32'(k); settle();
      chk($sformatf("fence_drain_%0d", k), 32'(grant_src), 32'd2);
      chk($sformatf("fence_load_rdy_%0d", k), 32'(load_req_ready), 32'd0);
    end
    tick(); sb_drain_valid = 1'b0; settle();
    chk("fence_done_pulse", 32'(fence_done), 32'd1);
    chk("fence_done_grant", 32'(grant_src), 32'd0);
    tick(); fence_req = 1'b0; settle();
    chk("after_fence_load", 32'(grant_src), 32'd1);
    chk("after_fence_done_low", 32'(fence_done), 32'd0);

    // Refill and fence arrive together: the line finishes, then the fence runs.
    tick(); load_req_valid = 1'b0; refill_valid = 1'b1; refill_addr = 32'h2000_0044;
    refill_data = 32'hB0; fence_req = 1'b1; settle();
    chk("conflict_b0_grant", 32'(grant_src), 32'd3);
    chk("conflict_b0_addr", arr_addr, 32'h2000_0040);
    for (int k = 1; k < LW; k++) begin
      tick(); refill_data = 32'hB0 + 32'(k); settle();
      chk($sformatf("conflict_b%0d_addr", k), arr_addr, 32'h2000_0040 + 32'(4 * k));
      chk($sformatf("conflict_b%0d_done", k), 32'(fence_done), 32'd0);
    end
    tick(); refill_valid = 1'b0; settle();
    chk("conflict_fence_enter", 32'(grant_src), 32'd0);
    tick(); settle();
    chk("conflict_fence_done", 32'(fence_done), 32'd1);
    tick(); fence_req = 1'b0; settle();
    chk("conflict_idle", 32'(fence_done), 32'd0);

    // Reset in the middle of a line: the next line restarts at beat 0.
    tick(); refill_valid = 1'b1; refill_addr = 32'h3000_0020; settle();
    chk("midrst_b0_addr", arr_addr, 32'h3000_0020);
    tick(); settle();
    tick(); settle();
    chk("midrst_b2_addr", arr_addr, 32'h3000_0028);
    tick(); reset = 1'b0; settle();
    chk("midrst_quiet", 32'({refill_ready, arr_en}) | 32'(grant_src), 32'd0);
    tick(); reset = 1'b1; refill_addr = 32'h4000_00F8; settle();
    chk("restart_b0_addr", arr_addr, 32'h4000_00F0);
    tick(); settle();
    chk("restart_b1_addr", arr_addr, 32'h4000_00F4);
    tick(); settle();
    tick(); settle();
    chk("restart_b3_addr", arr_addr, 32'h4000_00FC);
    tick(); refill_valid = 1'b0; settle();
    chk("restart_idle", 32'(grant_src), 32'd0);
    tick(); tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
